// File: rtl/cnn_port_arbiter_pkg.sv
// Shared accelerator definitions for the CNN-side RAM port arbiter.
// Defaults and index types reused by the arbiter and its sub-module.
package cnn_port_arbiter_pkg;

    localparam int NUM_CORES_DEFAULT = 4;
    localparam int MAX_LOCK_DEFAULT  = 16;
    localparam int LOCK_CNT_W        = 8;

    typedef logic [$clog2(NUM_CORES_DEFAULT)-1:0] core_idx_t;

endpackage

// File: rtl/cnn_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester searching upward
// (modulo NUM_CORES) from last_idx+1.
module cnn_port_arbiter_rr_pick
    import cnn_port_arbiter_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEFAULT,
    parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     last_idx,
    output logic [NUM_CORES-1:0] win_oh,
    output logic [IDX_W-1:0]     win_idx
);

    logic found;
    int   cand;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = (int'(last_idx) + k) % NUM_CORES;
            if (!found && req[cand]) begin
                found        = 1'b1;
                win_oh[cand] = 1'b1;
                win_idx      = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/cnn_port_arbiter.sv
// Round-robin arbiter sharing RAM port B among compute cores, with a
// bounded burst lock and registered read-data-valid routing.
module cnn_port_arbiter
    import cnn_port_arbiter_pkg::*;
#(
    parameter int NUM_CORES  = NUM_CORES_DEFAULT,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LOCK   = MAX_LOCK_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CORES-1:0]            core_req,
    input  logic [NUM_CORES-1:0]            core_we,
    input  logic [NUM_CORES-1:0]            core_lock,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] core_wdata,
    output logic [NUM_CORES-1:0]            core_gnt,
    output logic [NUM_CORES-1:0]            core_rvalid,
    output logic [DATA_WIDTH-1:0]           core_rdata,
    output logic                            ram_we,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    output logic [DATA_WIDTH-1:0]           ram_wdata,
    input  logic [DATA_WIDTH-1:0]           ram_q,
    output logic                            busy
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [IDX_W-1:0]      last_q, last_d;
    logic                  lock_valid_q, lock_valid_d;
    logic [IDX_W-1:0]      lock_owner_q, lock_owner_d;
    logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [NUM_CORES-1:0]  rvalid_q, rvalid_d;

    logic [NUM_CORES-1:0]  rr_oh;
    logic [IDX_W-1:0]      rr_idx;
    logic [IDX_W-1:0]      win_idx;
    logic [LOCK_CNT_W-1:0] cnt_inc;
    logic                  accept;

    cnn_port_arbiter_rr_pick #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req      (core_req),
        .last_idx (last_q),
        .win_oh   (rr_oh),
        .win_idx  (rr_idx)
    );

    always_comb begin
        core_gnt     = '0;
        win_idx      = rr_idx;
        last_d       = last_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_cnt_q;
        cnt_inc      = lock_cnt_q + LOCK_CNT_W'(1);

        // A held lock masks every other requester, even when the owner is idle.
        if (lock_valid_q) begin
            win_idx = lock_owner_q;
            if (core_req[lock_owner_q]) begin
                core_gnt[lock_owner_q] = 1'b1;
            end
        end else begin
            core_gnt = rr_oh;
        end
        if (rst) begin
            core_gnt = '0;
        end
        accept = |core_gnt;

        if (lock_valid_q && !core_req[lock_owner_q]) begin
            lock_valid_d = 1'b0;
            lock_cnt_d   = '0;
        end
        if (accept) begin
            last_d = win_idx;
            if (core_lock[win_idx] && (cnt_inc != LOCK_CNT_W'(MAX_LOCK))) begin
                lock_valid_d = 1'b1;
                lock_owner_d = win_idx;
                lock_cnt_d   = cnt_inc;
            end else begin
                lock_valid_d = 1'b0;
                lock_cnt_d   = '0;
            end
        end

        rvalid_d = core_gnt & ~core_we;
    end

    // One-hot grant lets the mux be an OR of gated slices; idle drives zeros.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (core_gnt[i]) begin
                ram_we    = core_we[i];
                ram_addr  = core_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                ram_wdata = core_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q       <= IDX_W'(NUM_CORES - 1);
            lock_valid_q <= 1'b0;
            lock_owner_q <= '0;
            lock_cnt_q   <= '0;
            rvalid_q     <= '0;
        end else begin
            last_q       <= last_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign core_rvalid = rvalid_q;
    assign core_rdata  = ram_q;
    assign busy        = (|core_req) | lock_valid_q;

endmodule

// File: tb/tb_cnn_port_arbiter.sv
// Directed bench for cnn_port_arbiter: 4 cores, MAX_LOCK=4, small RAM model
// with one-cycle read latency preloaded with mem[a] = a*7+3.
module tb_cnn_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    core_req, core_we, core_lock;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;
    logic [N-1:0]    core_gnt, core_rvalid;
    logic [DW-1:0]   core_rdata;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_q;
    logic            busy;

    logic [7:0] mem [256];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    cnn_port_arbiter #(
        .NUM_CORES  (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_LOCK   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_lock   (core_lock),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_q       (ram_q),
        .busy        (busy)
    );

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k * 7 + 3);
        end else if (ram_we) begin
            mem[ram_addr[7:0]] <= ram_wdata;
        end
        ram_q <= mem[ram_addr[7:0]];
    end

    function automatic logic [7:0] preload(input int a);
        return 8'(a * 7 + 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs half a cycle before the next rising edge; outputs settle by +1.
    task automatic drive(input logic [N-1:0] req, input logic [N-1:0] we, input logic [N-1:0] lck);
        @(negedge clk);
        core_req  = req;
        core_we   = we;
        core_lock = lck;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        core_req   = '0;
        core_we    = '0;
        core_lock  = '0;
        core_addr  = '0;
        core_wdata = '0;
        for (int i = 0; i < N; i++) core_addr[i*AW +: AW] = 32'h20 + 32'(i);

        // Reset state: outputs forced low even with every core requesting.
        drive(4'b1111, 4'b0000, 4'b0000);
        drive(4'b1111, 4'b0000, 4'b0000);
        check("rst_gnt", 32'(core_gnt), 32'h0);
        check("rst_rvalid", 32'(core_rvalid), 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);

        // Reset priority: grants 0,1,2,3 with reads returning preloaded bytes.
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (c > 0) drive(4'b1111, 4'b0000, 4'b0000);
            else #1;
            check($sformatf("rr_gnt%0d", c), 32'(core_gnt), 32'(1 << c));
            check($sformatf("rr_addr%0d", c), ram_addr, 32'h20 + 32'(c));
            if (c > 0) begin
                check($sformatf("rr_rvalid%0d", c), 32'(core_rvalid), 32'(1 << (c - 1)));
                check($sformatf("rr_rdata%0d", c), 32'(core_rdata), 32'(preload(32'h20 + c - 1)));
            end
        end

        // Idle: no grant, zeroed port, busy low, last kept at 3.
        drive(4'b0000, 4'b0000, 4'b0000);
        check("rr_rvalid3", 32'(core_rvalid), 32'h8);
        check("rr_rdata3", 32'(core_rdata), 32'(preload(32'h23)));
        check("idle_gnt", 32'(core_gnt), 32'h0);
        check("idle_we", 32'(ram_we), 32'h0);
        check("idle_addr", ram_addr, 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        drive(4'b0000, 4'b0000, 4'b0000);
        check("idle_rvalid", 32'(core_rvalid), 32'h0);
        check("idle_last", 32'(dut.last_q), 32'd3);

        // Write then read: core 2 writes A5 to 0x10, core 1 reads it back.
        core_addr[2*AW +: AW]  = 32'h10;
        core_wdata[2*DW +: DW] = 8'hA5;
        drive(4'b0100, 4'b0100, 4'b0000);
        check("wr_gnt", 32'(core_gnt), 32'h4);
        check("wr_we", 32'(ram_we), 32'h1);
        check("wr_addr", ram_addr, 32'h10);
        check("wr_wdata", 32'(ram_wdata), 32'hA5);
        core_addr[1*AW +: AW] = 32'h10;
        drive(4'b0010, 4'b0000, 4'b0000);
        check("rd_gnt", 32'(core_gnt), 32'h2);
        check("rd_we", 32'(ram_we), 32'h0);
        check("wr_no_rvalid", 32'(core_rvalid), 32'h0);
        drive(4'b0000, 4'b0000, 4'b0000);
        check("rd_rvalid", 32'(core_rvalid), 32'h2);
        check("rd_rdata", 32'(core_rdata), 32'hA5);

        // Lock cap with last=1: core 3 first, then bursts of four for core 1.
        begin
            int exp_win[10] = '{3, 1, 1, 1, 1, 3, 1, 1, 1, 1};
            for (int s = 0; s < 10; s++) begin
                drive(4'b1010, 4'b0000, 4'b0010);
                check($sformatf("lock_gnt%0d", s), 32'(core_gnt), 32'(1 << exp_win[s]));
            end
        end
        check("lock_busy", 32'(busy), 32'h1);
        drive(4'b0000, 4'b0000, 4'b0000);
        check("lock_cap_clear", 32'(dut.lock_valid_q), 32'h0);

        // Voluntary release: core 0 drops lock on its third grant, core 2 waiting.
        drive(4'b0001, 4'b0000, 4'b0001);
        check("vol_gnt1", 32'(core_gnt), 32'h1);
        drive(4'b0101, 4'b0000, 4'b0001);
        check("vol_gnt2", 32'(core_gnt), 32'h1);
        check("vol_locked", 32'(dut.lock_valid_q), 32'h1);
        drive(4'b0101, 4'b0000, 4'b0000);
        check("vol_gnt3", 32'(core_gnt), 32'h1);
        drive(4'b0100, 4'b0000, 4'b0000);
        check("vol_next", 32'(core_gnt), 32'h4);
        check("vol_unlocked", 32'(dut.lock_valid_q), 32'h0);

        // Owner drops req while locked: one empty cycle, then core 3.
        drive(4'b0010, 4'b0000, 4'b0010);
        check("drop_gnt", 32'(core_gnt), 32'h2);
        drive(4'b1000, 4'b0000, 4'b0000);
        check("drop_blocked", 32'(core_gnt), 32'h0);
        check("drop_busy", 32'(busy), 32'h1);
        drive(4'b1000, 4'b0000, 4'b0000);
        check("drop_next", 32'(core_gnt), 32'h8);

        // Sole requester granted back-to-back with rvalid held high.
        drive(4'b0001, 4'b0000, 4'b0000);
        check("sole_gnt0", 32'(core_gnt), 32'h1);
        drive(4'b0001, 4'b0000, 4'b0000);
        check("sole_gnt1", 32'(core_gnt), 32'h1);
        check("sole_rv1", 32'(core_rvalid), 32'h1);
        drive(4'b0000, 4'b0000, 4'b0000);
        check("sole_rv2", 32'(core_rvalid), 32'h1);
        check("sole_rdata", 32'(core_rdata), 32'(preload(32'h20)));

        // Reset mid-read: core 3 read granted, then reset sampled on the next edge.
        drive(4'b1000, 4'b0000, 4'b0000);
        check("rmr_gnt", 32'(core_gnt), 32'h8);
        @(negedge clk);
        rst       = 1'b1;
        core_req  = 4'b1001;
        core_we   = 4'b1001;
        #1;
        check("rmr_inflight", 32'(core_rvalid), 32'h8);
        check("rmr_gnt_forced", 32'(core_gnt), 32'h0);
        check("rmr_we_forced", 32'(ram_we), 32'h0);
        drive(4'b1001, 4'b1001, 4'b0000);
        check("rmr_rvalid_drop", 32'(core_rvalid), 32'h0);
        check("rmr_gnt_rst", 32'(core_gnt), 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        core_we = 4'b0000;
        #1;
        check("rmr_first", 32'(core_gnt), 32'h1);
        drive(4'b1001, 4'b0000, 4'b0000);
        check("rmr_second", 32'(core_gnt), 32'h8);
        drive(4'b0000, 4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/cnn_port_arbiter.md
# cnn_port_arbiter

Round-robin arbiter sharing the single CNN-side port (port B) of the dual-port feature/weight RAM among `NUM_CORES` compute cores. It serialises core accesses onto the RAM port, one per cycle, and routes read data back to the issuing core. An optional bounded lock lets one core hold the port for bursts. Port A remains owned by the Wishbone wrapper and is not touched by this block.

## Interface
- `NUM_CORES`, 4: number of requesting cores; 2–8.
- `ADDR_WIDTH`, 32: RAM address width, matching the RAM instance.
- `DATA_WIDTH`, 8: RAM data width, matching the RAM instance.
- `MAX_LOCK`, 16: maximum consecutive grants to one locked core; range 1–255.
- `clk`  in  1  single clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `core_req`  in  NUM_CORES  per-core access request.
- `core_we`  in  NUM_CORES  per-core write enable; 0 means read.
- `core_lock`  in  NUM_CORES  request to keep the grant on the next cycle.
- `core_addr`  in  NUM_CORES*ADDR_WIDTH  packed addresses; core i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `core_wdata`  in  NUM_CORES*DATA_WIDTH  packed write data, packed the same way.
- `core_gnt`  out  NUM_CORES  one-hot grant; combinational.
- `core_rvalid`  out  NUM_CORES  one-hot read-data-valid; registered.
- `core_rdata`  out  DATA_WIDTH  read data, broadcast to all cores; qualified by `core_rvalid`.
- `ram_we`  out  1  port B write enable.
- `ram_addr`  out  ADDR_WIDTH  port B address.
- `ram_wdata`  out  DATA_WIDTH  port B write data.
- `ram_q`  in  DATA_WIDTH  port B read data. It is valid one cycle after its address is presented.
- `busy`  out  1  high when any `core_req` is high or a lock is held.

## Operation
- Access is accepted on a rising edge where `core_gnt[i]=1`.
- A core holds `req`, `we`, `addr` and `wdata` stable until its grant is sampled.
- One access per cycle.
- Winner selection, when no lock is active: the first requesting core searching upward (modulo N) from `last+1`.
  - `last` is a register updated to the winner index on each accepted access.
  - Reset value of `last` is NUM_CORES-1, so core 0 wins first.
- Lock:
  - If a winner has `core_lock[i]=1` at acceptance, set `lock_valid=1`, `lock_owner=i`, and increment `lock_cnt`.
  - While `lock_valid` is set, only `lock_owner` can be granted. Other requests wait with grant 0.
  - The lock is released at the first edge where any of these holds:
    - the owner's `req` is 0;
    - the owner is granted with `lock=0`;
    - `lock_cnt` reaches MAX_LOCK. After this forced break, the next winner is picked by round-robin from `last+1`, so the owner cannot win immediately if others request.
  - On release, `lock_cnt` clears to 0.
- Grant mux:
  - When core i is granted: `ram_we=core_we[i]`, `ram_addr` and `ram_wdata` = core i's fields.
  - When no core is granted: `ram_we=0`, `ram_addr=0`, `ram_wdata=0`.
- Read return: a granted read (`we=0`) at edge T sets `core_rvalid[i]=1` for cycle T+1, with `core_rdata=ram_q`.
- Granted writes never assert `rvalid`.
- `core_rdata` passes `ram_q` through combinationally at all times.
- Reset clears `last`, `lock_valid`, `lock_owner`, `lock_cnt` and `core_rvalid`.
- While `rst=1`, `core_gnt`, `ram_we`, `ram_addr` and `ram_wdata` are forced to 0.

## Timing
- Grant latency: 0 cycles, same cycle as the request, when the core is the selected winner.
- Read latency: `core_rvalid` one cycle after the accepted edge.
- Throughput: one access per cycle in aggregate.
- A sole requester is granted every cycle.
- Starvation bound without locks: a waiting core is granted within NUM_CORES-1 cycles.
- Starvation bound with locks: within (NUM_CORES-1)*MAX_LOCK cycles.
- Simultaneous read return and new grant to the same core are legal; `rvalid` then stays high on consecutive cycles.
- `rst` asserted mid-lock or mid-read: the in-flight `rvalid` is dropped and the lock is cleared. Arbitration restarts at core 0.
- A `core_lock` bit on a non-granted core has no effect.

## Structure
- Shared accelerator package: `NUM_CORES_DEFAULT`, `MAX_LOCK_DEFAULT`, and a `core_idx_t` typedef sized as `$clog2(NUM_CORES)`.
- One sub-module, `rr_pick`: purely combinational. Inputs are the request vector and the `last` index; output is a one-hot winner plus its index.
- Top level holds the `last`, lock and `rvalid` registers, the packed-bus slicing, and the mux.

## Test plan
- **Reset priority.** After reset, `core_req=4'b1111`, all reads, no lock, for 4 cycles. Grants must be cores 0, 1, 2, 3 in order; `rvalid` follows each one cycle later with the preloaded RAM byte at that core's address.
- **Write then read.** Core 2 writes 0xA5 to address 0x10. Core 1 reads 0x10 on the next cycle. `core_rvalid=4'b0010` with `core_rdata=0xA5` one cycle after core 1's grant.
- **Lock cap.** MAX_LOCK=4; core 1 holds `req` and `lock` continuously, core 3 requests continuously. Grants follow the cycle pattern 1,1,1,1,3,1,1,1,1,3, and so on.
- **Voluntary release.** Core 0 is locked; it drops `lock` on its 3rd grant while core 2 waits. The next grant goes to core 2, and `lock_valid=0`.
- **Reset mid-read.** A granted read to core 3 is followed by `rst=1` on the next edge. `core_rvalid` must be 0 and `ram_we`/`core_gnt` must be 0 during reset. After release, the first grant among `4'b1001` goes to core 0.
- **Idle.** With `core_req=0`, `ram_we=0`, `ram_addr=0`, `busy=0`, and `last` is unchanged.
